pipe_reg_w2: RTL and testbench
==============================

# pipe_reg_w2

Parametrised M→W stage register for the MIPS pipeline. It carries instr, PC, PC+8, memory read data (D), ALU result (C) and destination register (A3) from the memory stage to the write-back stage. Unlike a plain flop bank, it adds:
- a valid bit per entry;
- a ready/valid handshake with an optional two-entry skid buffer, so write-back back-pressure does not combinationally reach the M stage;
- a synchronous flush;
- bubble masking of A3, so hazard/forwarding logic never matches an invalid entry;
- a saturating stall-cycle counter.

## Interface
Parameters:
- DATA_W, 32, width of instr/PC/PC8/D/C fields
- REG_W, 5, width of A3
- SKID, 1, 1 = registered in_ready with skid entry; 0 = single entry, combinational in_ready
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately on assertion
- flush  in  1  synchronous flush, drops all held and incoming entries
- in_valid  in  1  M stage presents an entry
- in_ready  out  1  block accepts the entry this cycle
- in_instr, in_pc, in_pc8, in_d, in_c  in  DATA_W each  M-stage fields
- in_a3  in  REG_W  M-stage destination register
- out_valid  out  1  W-stage entry valid
- out_ready  in  1  W stage consumes the entry this cycle
- out_instr, out_pc, out_pc8, out_d, out_c  out  DATA_W each  W-stage fields
- out_a3  out  REG_W  W-stage destination; forced 0 when out_valid=0
- stall_cnt  out  CNT_W  saturating count of cycles with in_valid=1 and in_ready=0

## Operation
State:
- main entry (valid + fields)
- skid entry (valid + fields), present only when SKID=1
- stall counter

Definitions:
- Accept = in_valid & in_ready & !flush.
- Drain = out_valid & out_ready.

SKID=1:
- in_ready = !skid_valid. This is a registered term only.
- Main empty, or Drain with skid empty: on Accept, main ← input.
- Drain with skid full: main ← skid, skid cleared. in_ready is 0 this cycle, so there is no Accept.
- Main full, no Drain, Accept: skid ← input. in_ready drops to 0 next cycle.
- Main full and Drain, no Accept: main_valid ← 0.

SKID=0:
- in_ready = !out_valid | out_ready.
- On Accept, main ← input.
- On Drain without Accept, main_valid ← 0.

Outputs:
- Output fields always show the main entry.
- out_a3 = out_valid ? main_a3 : 0.
- Invalid entries never present a nonzero A3.

Flush:
- Highest priority after reset.
- Next cycle: main_valid = skid_valid = 0.
- The input offered in the flush cycle is dropped.
- in_ready is 1 during flush, so the upstream stage sees its entry consumed.
- Fields other than valid may keep stale values; they are never observed through out_a3.

Counter:
- Increments when in_valid & !in_ready & !flush.
- Saturates at 2^CNT_W−1; no wrap.

Ordering: entries leave strictly in acceptance order; there is no duplication and no loss except on flush or reset.

## Timing
- Reset, while asserted: out_valid=0, all out_* fields=0 (out_pc included), out_a3=0, stall_cnt=0, internal skid_valid=0. in_ready=1 in both modes.
- Latency: an accepted entry appears on out_* on the next posedge.
- Throughput: 1 entry/cycle when out_ready is held 1.
- SKID=1 capacity: 2 entries. in_ready falls one cycle after the skid entry fills and rises one cycle after it drains.
- Reset asserted mid-operation: all entries are lost at once, independent of clk. The first Accept can occur on the first posedge after release.
- Flush together with Drain: the drained entry counts as consumed; nothing remains.

## Test plan
- Reset: drive reset=0 asynchronously between edges with fields full → out_valid=0, out_pc=0, out_a3=0, stall_cnt=0 immediately.
- Stream: SKID=1, out_ready=1, send 4 entries with in_a3=1,2,3,4 on consecutive cycles → out_a3=1,2,3,4 one cycle later, in_ready constantly 1, stall_cnt=0.
- Back-pressure: SKID=1, out_ready=0, send entries A3=7,8,9 → 7 held in main, 8 in skid, in_ready=0 from cycle 3, 9 held upstream. Release out_ready → outputs 7,8,9 in order, stall_cnt equals the number of blocked cycles.
- Flush: with main and skid full (A3=5,6), pulse flush alongside in_valid with A3=10 → next cycle out_valid=0, out_a3=0; 10 never appears; in_ready=1.
- Bubble masking: SKID=0, out_ready=1, in_valid=0 after an entry with A3=31 → one cycle out_a3=31, then out_a3=0 while out_instr holds its stale value.
- Saturation: CNT_W=4, hold in_valid=1 with out_ready=0 for 40 cycles → stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_reg_w2.sv
// rtl/pipe_reg_w2.sv - M->W pipeline stage register with valid/ready handshake, skid entry, flush and stall counter
module pipe_reg_w2 #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_pc8,
    input  logic [DATA_W-1:0] in_d,
    input  logic [DATA_W-1:0] in_c,
    input  logic [REG_W-1:0]  in_a3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_pc8,
    output logic [DATA_W-1:0] out_d,
    output logic [DATA_W-1:0] out_c,
    output logic [REG_W-1:0]  out_a3,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pc8;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] c;
        logic [REG_W-1:0]  a3;
    } entry_t;

    entry_t in_e;
    entry_t main_e;
    entry_t skid_e;
    logic   main_valid;
    logic   skid_valid;
    logic   accept;
    logic   drain;
    logic   stall;

    assign in_e = '{instr: in_instr, pc: in_pc, pc8: in_pc8, d: in_d, c: in_c, a3: in_a3};

    // Flush always reports ready so upstream sees its offered entry as consumed.
    generate
        if (SKID != 0) begin : g_ready_skid
            assign in_ready = flush | ~skid_valid;
        end else begin : g_ready_direct
            assign in_ready = flush | ~main_valid | out_ready;
        end
    endgenerate

    assign accept = in_valid & in_ready & ~flush;
    assign drain  = main_valid & out_ready;
    assign stall  = in_valid & ~in_ready & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_e     <= '0;
            skid_e     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (SKID != 0) begin
            if (skid_valid) begin
                // in_ready is low here, so no new entry can arrive this cycle.
                if (drain) begin
                    main_e     <= skid_e;
                    skid_valid <= 1'b0;
                end
            end else if (!main_valid || drain) begin
                if (accept) begin
                    main_e     <= in_e;
                    main_valid <= 1'b1;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_e     <= in_e;
                skid_valid <= 1'b1;
            end
        end else begin
            if (accept) begin
                main_e     <= in_e;
                main_valid <= 1'b1;
            end else if (drain) begin
                main_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign out_valid = main_valid;
    assign out_instr = main_e.instr;
    assign out_pc    = main_e.pc;
    assign out_pc8   = main_e.pc8;
    assign out_d     = main_e.d;
    assign out_c     = main_e.c;
    // Bubbles never expose a destination register to hazard/forwarding logic.
    assign out_a3    = main_valid ? main_e.a3 : '0;

endmodule

// File: tb/tb_pipe_reg_w2.sv
// tb/tb_pipe_reg_w2.sv - directed self-checking bench for pipe_reg_w2 (skid and direct variants)
module tb_pipe_reg_w2;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr, in_pc, in_pc8, in_d, in_c;
    logic [4:0]  in_a3;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_instr, a_out_pc, a_out_pc8, a_out_d, a_out_c;
    logic [4:0]  a_out_a3;
    logic [3:0]  a_stall_cnt;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_instr, b_out_pc, b_out_pc8, b_out_d, b_out_c;
    logic [4:0]  b_out_a3;
    logic [15:0] b_stall_cnt;

    int nvec = 0;
    int nerr = 0;

    pipe_reg_w2 #(.DATA_W(32), .REG_W(5), .SKID(1), .CNT_W(4)) u_a (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_pc8(in_pc8), .in_d(in_d), .in_c(in_c), .in_a3(in_a3),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_instr(a_out_instr), .out_pc(a_out_pc), .out_pc8(a_out_pc8), .out_d(a_out_d), .out_c(a_out_c),
        .out_a3(a_out_a3), .stall_cnt(a_stall_cnt)
    );

    pipe_reg_w2 #(.DATA_W(32), .REG_W(5), .SKID(0), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_pc8(in_pc8), .in_d(in_d), .in_c(in_c), .in_a3(in_a3),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_instr(b_out_instr), .out_pc(b_out_pc), .out_pc8(b_out_pc8), .out_d(b_out_d), .out_c(b_out_c),
        .out_a3(b_out_a3), .stall_cnt(b_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] a3);
        in_valid = v;
        in_a3    = a3;
        in_instr = 32'hA000_0000 | 32'(a3);
        in_pc    = 32'h0000_1000 + 32'(a3) * 4;
        in_pc8   = 32'h0000_1008 + 32'(a3) * 4;
        in_d     = 32'hD000_0000 | 32'(a3);
        in_c     = 32'hC000_0000 | 32'(a3);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 5'd0);
        #3;
        check("rst_valid", 64'(a_out_valid), 64'd0);
        check("rst_ready_a", 64'(a_in_ready), 64'd1);
        check("rst_ready_b", 64'(b_in_ready), 64'd1);
        check("rst_stall", 64'(a_stall_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Fill main and skid, accumulate a stall, then reset between edges.
        drive(1'b1, 5'd3); tick();
        check("fill_main", 64'(a_out_a3), 64'd3);
        drive(1'b1, 5'd4); tick();
        check("fill_skid_ready", 64'(a_in_ready), 64'd0);
        drive(1'b1, 5'd5); tick();
        check("pre_rst_stall", 64'(a_stall_cnt), 64'd1);
        check("pre_rst_pc", 64'(a_out_pc), 64'h100C);
        #3 reset = 1'b0;
        #1;
        check("arst_valid", 64'(a_out_valid), 64'd0);
        check("arst_pc", 64'(a_out_pc), 64'd0);
        check("arst_a3", 64'(a_out_a3), 64'd0);
        check("arst_stall", 64'(a_stall_cnt), 64'd0);
        check("arst_ready", 64'(a_in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 5'd0);

        // Stream at full rate.
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i));
            #1;
            check("stream_ready", 64'(a_in_ready), 64'd1);
            tick();
            check("stream_a3", 64'(a_out_a3), 64'(i));
            check("stream_b_a3", 64'(b_out_a3), 64'(i));
        end
        drive(1'b0, 5'd0); tick();
        check("stream_end_valid", 64'(a_out_valid), 64'd0);
        check("stream_stall", 64'(a_stall_cnt), 64'd0);

        // Back-pressure: 7 in main, 8 in skid, 9 held upstream.
        out_ready = 1'b0;
        drive(1'b1, 5'd7); tick();
        check("bp_main7", 64'(a_out_a3), 64'd7);
        drive(1'b1, 5'd8); tick();
        check("bp_ready_low", 64'(a_in_ready), 64'd0);
        drive(1'b1, 5'd9); tick();
        tick();
        check("bp_hold7", 64'(a_out_a3), 64'd7);
        check("bp_stall2", 64'(a_stall_cnt), 64'd2);
        out_ready = 1'b1; tick();
        check("bp_out8", 64'(a_out_a3), 64'd8);
        check("bp_ready_up", 64'(a_in_ready), 64'd1);
        tick();
        check("bp_out9", 64'(a_out_a3), 64'd9);
        drive(1'b0, 5'd0); tick();
        check("bp_empty", 64'(a_out_valid), 64'd0);
        check("bp_stall3", 64'(a_stall_cnt), 64'd3);

        // Flush with main and skid full; the flush-cycle entry is dropped.
        out_ready = 1'b0;
        drive(1'b1, 5'd5); tick();
        drive(1'b1, 5'd6); tick();
        check("fl_full", 64'(a_in_ready), 64'd0);
        drive(1'b1, 5'd10); flush = 1'b1;
        #1;
        check("fl_ready", 64'(a_in_ready), 64'd1);
        tick();
        flush = 1'b0; drive(1'b0, 5'd0);
        check("fl_valid", 64'(a_out_valid), 64'd0);
        check("fl_a3", 64'(a_out_a3), 64'd0);
        check("fl_ready_after", 64'(a_in_ready), 64'd1);
        check("fl_stall", 64'(a_stall_cnt), 64'd3);
        out_ready = 1'b1; tick(); tick();
        check("fl_no10", 64'(a_out_valid), 64'd0);

        // Direct variant: bubble masking and combinational ready.
        drive(1'b1, 5'd31); tick();
        check("bub_a3", 64'(b_out_a3), 64'd31);
        drive(1'b0, 5'd0); tick();
        check("bub_masked", 64'(b_out_a3), 64'd0);
        check("bub_valid", 64'(b_out_valid), 64'd0);
        check("bub_stale", 64'(b_out_instr), 64'hA000_001F);
        out_ready = 1'b0;
        drive(1'b1, 5'd12); tick();
        check("d_ready_low", 64'(b_in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        check("d_ready_comb", 64'(b_in_ready), 64'd1);
        tick();
        drive(1'b0, 5'd0); tick();

        // Saturation of the 4-bit stall counter.
        out_ready = 1'b0;
        drive(1'b1, 5'd2);
        for (int i = 0; i < 40; i++) tick();
        check("sat_stall", 64'(a_stall_cnt), 64'd15);
        check("sat_head", 64'(a_out_a3), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
